// File: rtl/tracer_mc.sv
// tracer_mc -- trace serializer / deserializer between FPGA trace lanes and
// the trace-buffer memory port.
//
// Trace mode (MODE_I=0): samples N = 2**clamp(NTRACE_I) lanes every DECIM_I+1
// cycles into a shadow word; completed words move to a store slot
// (DATA_O/STORE_O, held until STORE_PERM_I). A full slot plus a complete
// shadow blocks sampling and dropped samples are counted. The first accepted
// trigger latches its bit position.
// Stream mode (MODE_I=1): memory words are captured into a prefetch slot
// (LOAD_REQUEST_O/LOAD_GRANT_I/DATA_I), moved to an active slot, and handed
// out N bits at a time on FPGA_STREAM_O, advanced by FPGA_READ_I.
//
// Ports:
//   FPGA_CLK_I, RST_NI (sync, active-low)     clock / reset
//   MODE_I, NTRACE_I, DECIM_I                 static configuration
//   EVENT_POS_O, TRG_EVENT_O                  first-trigger position / flag
//   TRG_DELAYED_I, FPGA_TRIG_O                delayed trigger / stream valid
//   DATA_I, LOAD_REQUEST_O, LOAD_GRANT_I      memory read side
//   DATA_O, STORE_O, STORE_PERM_I             memory write side
//   FPGA_TRIG_I, FPGA_TRACE_I, FPGA_WRITE_VALID_O   trace lanes in
//   FPGA_READ_I, FPGA_STREAM_O                stream lanes out
//   DROP_CNT_O                                saturating drop counter
//
// Optional macro TRACER_MC_TRIG_EDGE_EN: trigger becomes rising-edge sensitive
// across consecutive sample cycles.
module tracer_mc #(
  parameter int WIDTH       = 32,
  parameter int MAX_TRACES  = 8,
  parameter int NTRACE_BITS = $clog2($clog2(MAX_TRACES) + 1),
  parameter int DROP_BITS   = 16
) (
  input  logic                     FPGA_CLK_I,
  input  logic                     RST_NI,
  input  logic                     MODE_I,
  input  logic [NTRACE_BITS-1:0]   NTRACE_I,
  input  logic [7:0]               DECIM_I,
  output logic [$clog2(WIDTH)-1:0] EVENT_POS_O,
  output logic                     TRG_EVENT_O,
  input  logic                     TRG_DELAYED_I,
  input  logic [WIDTH-1:0]         DATA_I,
  output logic                     LOAD_REQUEST_O,
  input  logic                     LOAD_GRANT_I,
  output logic [WIDTH-1:0]         DATA_O,
  output logic                     STORE_O,
  input  logic                     STORE_PERM_I,
  input  logic                     FPGA_TRIG_I,
  input  logic [MAX_TRACES-1:0]    FPGA_TRACE_I,
  output logic                     FPGA_WRITE_VALID_O,
  input  logic                     FPGA_READ_I,
  output logic [MAX_TRACES-1:0]    FPGA_STREAM_O,
  output logic                     FPGA_TRIG_O,
  output logic [DROP_BITS-1:0]     DROP_CNT_O
);

  localparam int LOG_MAX = $clog2(MAX_TRACES);
  localparam int PW      = $clog2(WIDTH);

  function automatic logic [DROP_BITS-1:0] sat_inc(input logic [DROP_BITS-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [NTRACE_BITS-1:0] ntr;
  logic [PW-1:0]          step, last_pos;
  logic [MAX_TRACES-1:0]  lane_mask;

  always_comb begin
    ntr = (NTRACE_I > NTRACE_BITS'(LOG_MAX)) ? NTRACE_BITS'(LOG_MAX) : NTRACE_I;
    // step wraps to 0 when N == WIDTH, which keeps the pointer pinned at 0
    step      = PW'(1) << ntr;
    last_pos  = PW'(0) - step;
    lane_mask = ~({MAX_TRACES{1'b1}} << (32'd1 << ntr));
  end

  // Trace-side state
  logic [7:0]           decim_q, decim_d;
  logic [WIDTH-1:0]     shadow_q, shadow_d, data_q, data_d;
  logic [PW-1:0]        wptr_q, wptr_d, pos_q, pos_d;
  logic                 full_q, full_d, store_q, store_d;
  logic                 trg_q, trg_d, dly_q, dly_d, prev_q, prev_d;
  logic [DROP_BITS-1:0] drop_q, drop_d;
  // Stream-side state
  logic [WIDTH-1:0]     pf_q, pf_d, act_q, act_d;
  logic                 pfv_q, pfv_d, actv_q, actv_d;
  logic [PW-1:0]        rptr_q, rptr_d;

  logic             sample, write_valid, accept, trig_cond, slot_free, rd;
  logic [WIDTH-1:0] merged;

  assign write_valid = !MODE_I && !(store_q && full_q);

  always_comb begin
    sample    = !MODE_I && (decim_q == 8'd0);
    accept    = sample && write_valid;
    slot_free = !store_q || STORE_PERM_I;
    merged    = (shadow_q & ~(WIDTH'(lane_mask) << wptr_q))
              | (WIDTH'(FPGA_TRACE_I & lane_mask) << wptr_q);
`ifdef TRACER_MC_TRIG_EDGE_EN
    trig_cond = FPGA_TRIG_I && !prev_q;
`else
    trig_cond = FPGA_TRIG_I;
`endif
    rd        = MODE_I && FPGA_READ_I && actv_q;

    decim_d  = decim_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    wptr_d   = wptr_q;
    pos_d    = pos_q;
    full_d   = full_q;
    store_d  = store_q;
    trg_d    = trg_q;
    dly_d    = dly_q;
    prev_d   = prev_q;
    drop_d   = drop_q;
    pf_d     = pf_q;
    pfv_d    = pfv_q;
    act_d    = act_q;
    actv_d   = actv_q;
    rptr_d   = rptr_q;

    if (!MODE_I) begin
      decim_d = (decim_q >= DECIM_I) ? 8'd0 : decim_q + 8'd1;
      dly_d   = TRG_DELAYED_I;
      if (sample) prev_d = FPGA_TRIG_I;
      if (sample && !write_valid) drop_d = sat_inc(drop_q);
      if (accept && trig_cond && !trg_q) begin
        trg_d = 1'b1;
        pos_d = wptr_q;
      end

      if (full_q) begin
        // Complete shadow waits for the slot; no sample is accepted meanwhile
        if (STORE_PERM_I) begin
          data_d = shadow_q;
          full_d = 1'b0;
        end
      end else if (accept && (wptr_q == last_pos)) begin
        wptr_d = '0;
        if (slot_free) begin
          data_d  = merged;
          store_d = 1'b1;
        end else begin
          shadow_d = merged;
          full_d   = 1'b1;
        end
      end else begin
        if (accept) begin
          shadow_d = merged;
          wptr_d   = wptr_q + step;
        end
        if (store_q && STORE_PERM_I) store_d = 1'b0;
      end
    end else begin
      if (actv_q) begin
        if (rd) begin
          rptr_d = rptr_q + step;
          if (rptr_q == last_pos) begin
            if (pfv_q) begin
              act_d = pf_q;
              pfv_d = 1'b0;
            end else begin
              actv_d = 1'b0;
            end
          end
        end
      end else if (pfv_q) begin
        act_d  = pf_q;
        actv_d = 1'b1;
        pfv_d  = 1'b0;
      end
      // Grants only land in an empty slot, and the moves above need a full one
      if (LOAD_GRANT_I && !pfv_q) begin
        pf_d  = DATA_I;
        pfv_d = 1'b1;
      end
    end
  end

  always_ff @(posedge FPGA_CLK_I) begin
    if (!RST_NI) begin
      decim_q  <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      wptr_q   <= '0;
      pos_q    <= '0;
      full_q   <= 1'b0;
      store_q  <= 1'b0;
      trg_q    <= 1'b0;
      dly_q    <= 1'b0;
      prev_q   <= 1'b1;
      drop_q   <= '0;
      pf_q     <= '0;
      pfv_q    <= 1'b0;
      act_q    <= '0;
      actv_q   <= 1'b0;
      rptr_q   <= '0;
    end else begin
      decim_q  <= decim_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      wptr_q   <= wptr_d;
      pos_q    <= pos_d;
      full_q   <= full_d;
      store_q  <= store_d;
      trg_q    <= trg_d;
      dly_q    <= dly_d;
      prev_q   <= prev_d;
      drop_q   <= drop_d;
      pf_q     <= pf_d;
      pfv_q    <= pfv_d;
      act_q    <= act_d;
      actv_q   <= actv_d;
      rptr_q   <= rptr_d;
    end
  end

  assign EVENT_POS_O        = pos_q;
  assign TRG_EVENT_O        = trg_q;
  assign DATA_O             = data_q;
  assign STORE_O            = store_q;
  assign DROP_CNT_O         = drop_q;
  assign FPGA_WRITE_VALID_O = write_valid;
  assign LOAD_REQUEST_O     = MODE_I && !pfv_q;
  assign FPGA_TRIG_O        = MODE_I ? actv_q : dly_q;
  assign FPGA_STREAM_O      = actv_q ? (MAX_TRACES'(act_q >> rptr_q) & lane_mask)
                                     : '0;

endmodule

// File: tb/tb_tracer_mc.sv
// Directed bench for tracer_mc (WIDTH=32, MAX_TRACES=8).
module tb_tracer_mc;

  logic        clk = 1'b0;
  logic        rst_n, mode, trg_delayed, load_grant, store_perm;
  logic        fpga_trig, fpga_read;
  logic [1:0]  ntrace;
  logic [7:0]  decim, fpga_trace;
  logic [31:0] data_i;
  logic [4:0]  event_pos;
  logic        trg_event, load_req, store_o, wv, trig_o;
  logic [31:0] data_o;
  logic [7:0]  stream;
  logic [15:0] drop;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tracer_mc dut (
    .FPGA_CLK_I(clk), .RST_NI(rst_n), .MODE_I(mode), .NTRACE_I(ntrace),
    .DECIM_I(decim), .EVENT_POS_O(event_pos), .TRG_EVENT_O(trg_event),
    .TRG_DELAYED_I(trg_delayed), .DATA_I(data_i), .LOAD_REQUEST_O(load_req),
    .LOAD_GRANT_I(load_grant), .DATA_O(data_o), .STORE_O(store_o),
    .STORE_PERM_I(store_perm), .FPGA_TRIG_I(fpga_trig), .FPGA_TRACE_I(fpga_trace),
    .FPGA_WRITE_VALID_O(wv), .FPGA_READ_I(fpga_read), .FPGA_STREAM_O(stream),
    .FPGA_TRIG_O(trig_o), .DROP_CNT_O(drop)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic m, input logic [1:0] n);
    rst_n = 1'b0; mode = m; ntrace = n;
    trg_delayed = 0; load_grant = 0; store_perm = 0; fpga_trig = 0;
    fpga_read = 0; fpga_trace = '0; data_i = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] w1, w2, word;
    int n_lanes, nsamp, v;
    logic [7:0] exp_chunk;

    decim = 8'd0;
    // Reset values, trace mode
    do_reset(1'b0, 2'd0);
    chk("rst_store", store_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_wv", wv, 1);
    chk("rst_loadreq", load_req, 0);
    chk("rst_trgev", trg_event, 0);
    chk("rst_pos", event_pos, 0);
    chk("rst_drop", drop, 0);
    chk("rst_trigo", trig_o, 0);
    chk("rst_stream", stream, 0);

    // Word assembly for every lane count, upper lanes carry junk
    for (int n = 0; n < 4; n++) begin
      do_reset(1'b0, 2'(n));
      store_perm = 1'b1;
      word = $urandom;
      n_lanes = 1 << n;
      nsamp = 32 / n_lanes;
      for (int k = 0; k < nsamp; k++) begin
        v = int'((word >> (k * n_lanes)) & ((32'd1 << n_lanes) - 1)) | int'($urandom << n_lanes);
        fpga_trace = v[7:0];
        tick();
        if (k < nsamp - 1) chk($sformatf("asm%0d_early_store", n), store_o, 0);
      end
      chk($sformatf("asm%0d_store", n), store_o, 1);
      chk($sformatf("asm%0d_data", n), data_o, word);
    end

    // Trigger position latch, N=4: sample 3 -> bit 12, later trigger ignored
    do_reset(1'b0, 2'd2);
    store_perm = 1'b1;
    for (int i = 0; i < 8; i++) begin
      fpga_trig = (i == 3) || (i == 5);
      fpga_trace = 8'($urandom);
      tick();
      if (i == 2) chk("trg_before", trg_event, 0);
      if (i == 3) begin
        chk("trg_event", trg_event, 1);
        chk("trg_pos", event_pos, 12);
      end
      if (i == 5) chk("trg_pos_sticky", event_pos, 12);
    end
    fpga_trig = 1'b0;
    trg_delayed = 1'b1;
    tick();
    chk("trigo_dly_hi", trig_o, 1);
    trg_delayed = 1'b0;
    tick();
    chk("trigo_dly_lo", trig_o, 0);

    // Backpressure: two words held, three drops, then drain in order
    do_reset(1'b0, 2'd3);
    w1 = $urandom;
    w2 = $urandom;
    for (int k = 0; k < 4; k++) begin
      fpga_trace = w1[8*k +: 8];
      tick();
    end
    chk("bp_store1", store_o, 1);
    chk("bp_data1", data_o, w1);
    chk("bp_wv1", wv, 1);
    for (int k = 0; k < 4; k++) begin
      fpga_trace = w2[8*k +: 8];
      tick();
    end
    chk("bp_wv_blocked", wv, 0);
    chk("bp_data_hold", data_o, w1);
    for (int k = 0; k < 3; k++) begin
      fpga_trace = 8'($urandom);
      tick();
    end
    chk("bp_drop3", drop, 3);
    chk("bp_data_hold2", data_o, w1);
    store_perm = 1'b1;
    tick();
    chk("bp_data2", data_o, w2);
    chk("bp_store2", store_o, 1);
    chk("bp_wv_again", wv, 1);
    chk("bp_drop4", drop, 4);
    tick();
    chk("bp_store_done", store_o, 0);

    // Decimation: one sample every 4 cycles, N=8
    decim = 8'd3;
    do_reset(1'b0, 2'd3);
    store_perm = 1'b1;
    word = $urandom;
    for (int c = 0; c < 13; c++) begin
      fpga_trace = (c % 4 == 0) ? word[8*(c/4) +: 8] : 8'($urandom);
      tick();
      if (c == 11) chk("dec_early", store_o, 0);
    end
    chk("dec_store", store_o, 1);
    chk("dec_data", data_o, word);
    decim = 8'd0;

    // Stream mode, N=2, two words back to back
    do_reset(1'b1, 2'd1);
    chk("srst_loadreq", load_req, 1);
    chk("srst_wv", wv, 0);
    chk("srst_trigo", trig_o, 0);
    w1 = $urandom;
    w2 = $urandom;
    load_grant = 1'b1;
    data_i = w1;
    tick();
    chk("s_pf_full", load_req, 0);
    data_i = w2;
    tick();
    chk("s_active", trig_o, 1);
    chk("s_req_again", load_req, 1);
    fpga_read = 1'b1;
    for (int k = 0; k < 32; k++) begin
      exp_chunk = 8'(((k < 16) ? w1 : w2) >> (2 * (k % 16))) & 8'h03;
      chk($sformatf("s_valid%0d", k), trig_o, 1);
      chk($sformatf("s_chunk%0d", k), stream, exp_chunk);
      tick();
      if (k == 0) load_grant = 1'b0;
    end
    chk("s_end_trigo", trig_o, 0);
    chk("s_end_stream", stream, 0);
    chk("s_store_zero", store_o, 0);

    // Stream mode, random reads, reset mid-word
    fpga_read = 1'b0;
    do_reset(1'b1, 2'd2);
    load_grant = 1'b1;
    data_i = $urandom;
    tick();
    tick();
    data_i = $urandom;
    tick();
    load_grant = 1'b0;
    for (int k = 0; k < 3; k++) begin
      fpga_read = 1'($urandom_range(0, 1));
      tick();
    end
    chk("mid_valid", trig_o, 1);
    rst_n = 1'b0;
    tick();
    chk("mid_loadreq", load_req, 1);
    chk("mid_trigo", trig_o, 0);
    chk("mid_stream", stream, 0);
    chk("mid_store", store_o, 0);
    chk("mid_data", data_o, 0);
    chk("mid_wv", wv, 0);
    chk("mid_drop", drop, 0);
    chk("mid_trgev", trg_event, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
